// File: rtl/edf_pkg.sv
// Shared types and the wrap-aware deadline comparison for the EDF preemption controller.
package edf_pkg;

   localparam int unsigned IdMaxW = 8;
   localparam int unsigned TsMaxW = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACK
   } edf_state_e;

   typedef struct packed {
      logic [IdMaxW-1:0] id;
      logic [TsMaxW-1:0] dl;
   } edf_entry_t;

   // a is strictly earlier than b when bit w-1 of (a - b) is set; upper bits are ignored
   function automatic logic dl_before(input logic [TsMaxW-1:0] a,
                                      input logic [TsMaxW-1:0] b,
                                      input int unsigned       w);
      logic [TsMaxW-1:0] diff;
      logic [TsMaxW-1:0] msb_mask;
      diff     = a - b;
      msb_mask = TsMaxW'(1) << (w - 1);
      return |(diff & msb_mask);
   endfunction

endpackage

// File: rtl/edf_dl_stack.sv
// LIFO of preempted handler entries; a same-cycle pop and push replaces the top.
module edf_dl_stack
   import edf_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter type entry_t = edf_entry_t,
   localparam int unsigned LvlW = $clog2(Depth + 1),
   localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  entry_t          entry_i,
   output entry_t          top_o,
   output logic [LvlW-1:0] level_o,
   output logic            full_o,
   output logic            empty_o
);

   entry_t          mem_reg [Depth];
   entry_t          top_reg;
   logic [LvlW-1:0] level_reg;
   logic            do_pop;
   logic            do_push;
   logic [IdxW-1:0] wr_idx;
   logic [IdxW-1:0] below_idx;

   assign empty_o = (level_reg == '0);
   assign full_o  = (level_reg == LvlW'(Depth));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (do_pop | ~full_o);

   // the pop lands first, so a combined pop+push writes over the old top slot
   assign wr_idx    = do_pop ? IdxW'(level_reg - LvlW'(1)) : IdxW'(level_reg);
   assign below_idx = IdxW'(level_reg - LvlW'(2));

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_reg[wr_idx] <= entry_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         level_reg <= '0;
         top_reg   <= '0;
      end else if (do_push) begin
         top_reg <= entry_i;
         if (!do_pop) begin
            level_reg <= level_reg + LvlW'(1);
         end
      end else if (do_pop) begin
         level_reg <= level_reg - LvlW'(1);
         top_reg   <= (level_reg > LvlW'(1)) ? mem_reg[below_idx] : '0;
      end
   end

   assign top_o   = top_reg;
   assign level_o = level_reg;

endmodule

// File: rtl/edf_preempt_ctrl.sv
// Decides whether the EDF winner may preempt the running handler and runs the core claim handshake.
module edf_preempt_ctrl
   import edf_pkg::*;
#(
   parameter int unsigned NrIrqs  = 4,
   parameter int unsigned TsWidth = 24,
   parameter int unsigned Depth   = 4,
   localparam int unsigned IdWidth = $clog2(NrIrqs),
   localparam int unsigned LvlW    = $clog2(Depth + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [63:0]        mtime_i,
   input  logic               irq_valid_i,
   input  logic [IdWidth-1:0] irq_id_i,
   input  logic [TsWidth-1:0] irq_dl_i,
   output logic               irq_ack_o,
   output logic [IdWidth-1:0] irq_ack_id_o,
   output logic               core_req_o,
   output logic [IdWidth-1:0] core_id_o,
   output logic [TsWidth-1:0] core_dl_o,
   input  logic               core_ack_i,
   input  logic               core_mret_i,
   output logic [LvlW-1:0]    level_o,
   output logic [TsWidth-1:0] thresh_dl_o,
   output logic               dl_miss_o,
   output logic [7:0]         miss_cnt_o,
   output logic               underflow_o
);

   edf_state_e         state_reg;
   logic               core_req_reg;
   logic [IdWidth-1:0] core_id_reg;
   logic [TsWidth-1:0] core_dl_reg;
   logic               ack_reg;
   logic [IdWidth-1:0] ack_id_reg;
   logic               miss_reg;
   logic [7:0]         miss_cnt_reg;
   logic               underflow_reg;

   edf_entry_t         top_entry;
   edf_entry_t         push_entry;
   logic [LvlW-1:0]    level;
   logic               full;
   logic               empty;
   logic               eligible;
   logic               push;
   logic               miss_now;
   logic               unused_bits;

   assign eligible = irq_valid_i & ~full &
                     (empty | dl_before(TsMaxW'(irq_dl_i), top_entry.dl, TsWidth));
   assign push     = (state_reg == ST_REQ) & eligible & core_ack_i;
   assign miss_now = ~empty & dl_before(top_entry.dl, TsMaxW'(mtime_i[TsWidth-1:0]), TsWidth);

   always_comb begin
      push_entry    = '0;
      push_entry.id = IdMaxW'(core_id_reg);
      push_entry.dl = TsMaxW'(core_dl_reg);
   end

   edf_dl_stack #(
      .Depth   (Depth),
      .entry_t (edf_entry_t)
   ) u_stack (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (core_mret_i),
      .entry_i (push_entry),
      .top_o   (top_entry),
      .level_o (level),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= ST_IDLE;
         core_req_reg <= 1'b0;
         core_id_reg  <= '0;
         core_dl_reg  <= '0;
         ack_reg      <= 1'b0;
         ack_id_reg   <= '0;
      end else begin
         ack_reg <= 1'b0;
         unique case (state_reg)
            ST_IDLE: begin
               if (eligible) begin
                  core_id_reg  <= irq_id_i;
                  core_dl_reg  <= irq_dl_i;
                  core_req_reg <= 1'b1;
                  state_reg    <= ST_REQ;
               end else begin
                  core_req_reg <= 1'b0;
               end
            end
            ST_REQ: begin
               if (!eligible) begin
                  core_req_reg <= 1'b0;
                  state_reg    <= ST_IDLE;
               end else if (core_ack_i) begin
                  core_req_reg <= 1'b0;
                  ack_reg      <= 1'b1;
                  ack_id_reg   <= core_id_reg;
                  state_reg    <= ST_ACK;
               end else begin
                  // keep offering the freshest winner until the core takes it
                  core_id_reg <= irq_id_i;
                  core_dl_reg <= irq_dl_i;
               end
            end
            ST_ACK: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         miss_reg      <= 1'b0;
         miss_cnt_reg  <= '0;
         underflow_reg <= 1'b0;
      end else begin
         miss_reg <= miss_now;
         if (miss_now && !miss_reg && miss_cnt_reg != 8'hFF) begin
            miss_cnt_reg <= miss_cnt_reg + 8'd1;
         end
         if (core_mret_i && empty) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign unused_bits = ^{top_entry.id, mtime_i[63:TsWidth]};

   assign irq_ack_o    = ack_reg;
   assign irq_ack_id_o = ack_id_reg;
   assign core_req_o   = core_req_reg;
   assign core_id_o    = core_id_reg;
   assign core_dl_o    = core_dl_reg;
   assign level_o      = level;
   assign thresh_dl_o  = top_entry.dl[TsWidth-1:0];
   assign dl_miss_o    = miss_reg;
   assign miss_cnt_o   = miss_cnt_reg;
   assign underflow_o  = underflow_reg;

endmodule

// File: tb/tb_edf_preempt_ctrl.sv
// Directed bench for edf_preempt_ctrl with hand-computed expectations.
module tb_edf_preempt_ctrl;

   logic        clk;
   logic        rst;
   logic [63:0] mtime;
   logic        irq_valid;
   logic [1:0]  irq_id;
   logic [23:0] irq_dl;
   logic        irq_ack;
   logic [1:0]  irq_ack_id;
   logic        core_req;
   logic [1:0]  core_id;
   logic [23:0] core_dl;
   logic        core_ack;
   logic        core_mret;
   logic [2:0]  level;
   logic [23:0] thresh_dl;
   logic        dl_miss;
   logic [7:0]  miss_cnt;
   logic        underflow;

   int errors = 0;
   int checks = 0;

   edf_preempt_ctrl #(
      .NrIrqs  (4),
      .TsWidth (24),
      .Depth   (4)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .mtime_i      (mtime),
      .irq_valid_i  (irq_valid),
      .irq_id_i     (irq_id),
      .irq_dl_i     (irq_dl),
      .irq_ack_o    (irq_ack),
      .irq_ack_id_o (irq_ack_id),
      .core_req_o   (core_req),
      .core_id_o    (core_id),
      .core_dl_o    (core_dl),
      .core_ack_i   (core_ack),
      .core_mret_i  (core_mret),
      .level_o      (level),
      .thresh_dl_o  (thresh_dl),
      .dl_miss_o    (dl_miss),
      .miss_cnt_o   (miss_cnt),
      .underflow_o  (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      irq_valid = 1'b0;
      irq_id    = '0;
      irq_dl    = '0;
      core_ack  = 1'b0;
      core_mret = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},       64'(core_req),   64'd0);
      chk({tag, "_core_id"},   64'(core_id),    64'd0);
      chk({tag, "_core_dl"},   64'(core_dl),    64'd0);
      chk({tag, "_ack"},       64'(irq_ack),    64'd0);
      chk({tag, "_ack_id"},    64'(irq_ack_id), 64'd0);
      chk({tag, "_level"},     64'(level),      64'd0);
      chk({tag, "_thresh"},    64'(thresh_dl),  64'd0);
      chk({tag, "_miss"},      64'(dl_miss),    64'd0);
      chk({tag, "_miss_cnt"},  64'(miss_cnt),   64'd0);
      chk({tag, "_underflow"}, 64'(underflow),  64'd0);
   endtask

   // full handshake from IDLE: offer, core ack, claim pulse, controller clears valid
   task automatic claim(input logic [1:0] id, input logic [23:0] dl, input logic [2:0] exp_level);
      irq_valid = 1'b1;
      irq_id    = id;
      irq_dl    = dl;
      step();
      chk("claim_req", 64'(core_req), 64'd1);
      chk("claim_core_id", 64'(core_id), 64'(id));
      core_ack = 1'b1;
      step();
      chk("claim_ack", 64'(irq_ack), 64'd1);
      chk("claim_ack_id", 64'(irq_ack_id), 64'(id));
      chk("claim_req_drop", 64'(core_req), 64'd0);
      chk("claim_level", 64'(level), 64'(exp_level));
      chk("claim_thresh", 64'(thresh_dl), 64'(dl));
      irq_valid = 1'b0;
      core_ack  = 1'b0;
      step();
      chk("claim_ack_pulse_end", 64'(irq_ack), 64'd0);
      $display("claim id=%0d dl=0x%0h level=%0d", id, dl, level);
   endtask

   initial begin
      mtime = 64'd0;
      do_reset();
      chk_all_zero("reset");

      // basic claim plus non-preemption on equal and later deadlines
      claim(2'd2, 24'h000100, 3'd1);
      irq_valid = 1'b1; irq_id = 2'd1; irq_dl = 24'h000100;
      step();
      chk("equal_dl_no_req", 64'(core_req), 64'd0);
      irq_dl = 24'h000200;
      step();
      chk("later_dl_no_req", 64'(core_req), 64'd0);
      irq_valid = 1'b0;
      step();
      claim(2'd1, 24'h0000FF, 3'd2);

      // wrap-aware ordering, offer swap and withdraw
      do_reset();
      mtime = 64'h0000_0000_00FF_FF00;
      claim(2'd0, 24'hFFFFF0, 3'd1);
      irq_valid = 1'b1; irq_id = 2'd1; irq_dl = 24'h000010;
      step();
      chk("wrap_later_no_req", 64'(core_req), 64'd0);
      irq_dl = 24'hFFFFE0;
      step();
      chk("wrap_earlier_req", 64'(core_req), 64'd1);
      chk("wrap_earlier_dl", 64'(core_dl), 64'hFFFFE0);
      irq_id = 2'd3; irq_dl = 24'hFFFFD0;
      step();
      chk("swap_id", 64'(core_id), 64'd3);
      chk("swap_dl", 64'(core_dl), 64'hFFFFD0);
      chk("swap_req", 64'(core_req), 64'd1);
      irq_valid = 1'b0;
      step();
      chk("withdraw_req", 64'(core_req), 64'd0);
      chk("withdraw_ack", 64'(irq_ack), 64'd0);
      step();
      chk("withdraw_idle_ack", 64'(irq_ack), 64'd0);
      chk("withdraw_idle_req", 64'(core_req), 64'd0);
      chk("withdraw_level", 64'(level), 64'd1);

      // depth limit, pop+push, underflow
      do_reset();
      mtime = 64'd0;
      claim(2'd0, 24'h000400, 3'd1);
      claim(2'd1, 24'h000300, 3'd2);
      claim(2'd2, 24'h000200, 3'd3);
      claim(2'd3, 24'h000100, 3'd4);
      irq_valid = 1'b1; irq_id = 2'd0; irq_dl = 24'h000050;
      step();
      chk("full_no_req", 64'(core_req), 64'd0);
      step();
      chk("full_no_req2", 64'(core_req), 64'd0);
      irq_valid = 1'b0;
      core_mret = 1'b1;
      step();
      chk("pop_level3", 64'(level), 64'd3);
      chk("pop_thresh3", 64'(thresh_dl), 64'h200);
      step();
      chk("pop_level2", 64'(level), 64'd2);
      chk("pop_thresh2", 64'(thresh_dl), 64'h300);
      core_mret = 1'b0;
      irq_valid = 1'b1; irq_id = 2'd1; irq_dl = 24'h000250;
      step();
      chk("swap_top_req", 64'(core_req), 64'd1);
      core_ack  = 1'b1;
      core_mret = 1'b1;
      step();
      chk("swap_top_level", 64'(level), 64'd2);
      chk("swap_top_thresh", 64'(thresh_dl), 64'h250);
      chk("swap_top_ack", 64'(irq_ack), 64'd1);
      chk("swap_top_ack_id", 64'(irq_ack_id), 64'd1);
      irq_valid = 1'b0; core_ack = 1'b0;
      step();
      chk("below_level1", 64'(level), 64'd1);
      chk("below_thresh1", 64'(thresh_dl), 64'h400);
      step();
      chk("empty_level", 64'(level), 64'd0);
      chk("empty_thresh", 64'(thresh_dl), 64'd0);
      chk("no_underflow_yet", 64'(underflow), 64'd0);
      step();
      chk("underflow_set", 64'(underflow), 64'd1);
      core_mret = 1'b0;
      step();
      chk("underflow_sticky", 64'(underflow), 64'd1);
      chk("underflow_level", 64'(level), 64'd0);

      // deadline miss against a ramping mtime
      do_reset();
      mtime = 64'h40;
      claim(2'd2, 24'h000050, 3'd1);
      chk("miss_before_ramp", 64'(dl_miss), 64'd0);
      for (int m = 'h41; m <= 'h60; m++) begin
         mtime = 64'(m);
         step();
         chk($sformatf("miss_at_%0h", m), 64'(dl_miss), 64'(m > 'h50));
      end
      chk("miss_cnt_one", 64'(miss_cnt), 64'd1);
      core_mret = 1'b1;
      step();
      core_mret = 1'b0;
      step();
      chk("miss_clear_after_pop", 64'(dl_miss), 64'd0);
      chk("miss_cnt_hold", 64'(miss_cnt), 64'd1);

      // reset dropping a claim that the core just took
      do_reset();
      mtime = 64'd0;
      irq_valid = 1'b1; irq_id = 2'd3; irq_dl = 24'h000080;
      step();
      chk("rst_req_up", 64'(core_req), 64'd1);
      core_ack = 1'b1;
      rst      = 1'b1;
      step();
      chk_all_zero("rst_in_req");
      rst = 1'b0; core_ack = 1'b0; irq_valid = 1'b0;
      step();
      chk("rst_in_req_no_ack", 64'(irq_ack), 64'd0);

      // reset landing while the claim pulse is out
      irq_valid = 1'b1; irq_id = 2'd2; irq_dl = 24'h000090;
      step();
      core_ack = 1'b1;
      step();
      chk("ack_before_rst", 64'(irq_ack), 64'd1);
      rst = 1'b1; core_ack = 1'b0; irq_valid = 1'b0;
      step();
      chk_all_zero("rst_in_ack");
      rst = 1'b0;
      step();
      chk("rst_in_ack_no_ack", 64'(irq_ack), 64'd0);
      chk("rst_in_ack_level", 64'(level), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
